execute_memory: RTL and testbench
=================================

EXECUTE_MEMORY -- requirements
Module: execute_memory

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs A, B, DX_PC, DX_immediate  input  32 each  operands, PC, immediate/store data from decode.
REQ-004 SHALL have inputs RD  input  5  destination register; ALUctr  input  3  ALU op; DX_compareFlag  input  3  branch class.
REQ-005 SHALL have inputs DX_lwFlag, DX_swFlag  input  1 each  load / store markers.
REQ-006 SHALL have outputs MW_RD  output  5; MW_ALUout  output  32; MW_compareFlag  output  3.
REQ-007 SHALL have outputs branch_taken  output  1; branch_target  output  32; stall  output  1  upstream hold request.
REQ-008 SHALL have memory ports dmem_req, dmem_we  output  1; dmem_addr, dmem_wdata  output  32; dmem_rdata  input  32; dmem_ack  input  1.

Function
REQ-009 SHALL decode ALUctr: 0 = A+B, 1 = A-B, 2 = compare; 3..7 SHALL produce result 0; all arithmetic SHALL be 32-bit modulo 2^32.
REQ-010 With ALUctr=2, DX_compareFlag=0 (slt), result SHALL be 1 if A<B as signed 32-bit, else 0.
REQ-011 DX_compareFlag=1 (beq) SHALL set taken when A==B; 3 (bne) when A!=B; target = DX_PC+4+(DX_immediate<<2).
REQ-012 DX_compareFlag=2 (j) SHALL set taken unconditionally; target = {DX_PC[31:28], B[25:0], 2'b00}.
REQ-013 branch_taken SHALL be a registered one-cycle pulse; branch_target SHALL be registered with it and hold its value until the next taken branch.
REQ-014 For branch/jump instructions, MW_RD SHALL be 0 and MW_ALUout the compare result (1 when taken, else 0).
REQ-015 MW_compareFlag SHALL register DX_compareFlag each consumed instruction; 0 during bubbles.
REQ-016 Non-memory instructions SHALL complete in 1 cycle: MW_* valid the cycle after sampling.
REQ-017 FSM states SHALL be IDLE and MEM_WAIT.
REQ-018 IDLE with DX_lwFlag or DX_swFlag high SHALL latch dmem_addr=A+B, dmem_we=DX_swFlag, dmem_wdata=DX_immediate, and enter MEM_WAIT.
REQ-019 dmem_req SHALL equal (state==MEM_WAIT); dmem_addr/we/wdata SHALL stay stable until ack.
REQ-020 stall SHALL be combinational: (IDLE and (lwFlag or swFlag)) or (MEM_WAIT and not dmem_ack).
REQ-021 MEM_WAIT with dmem_ack SHALL return to IDLE and consume the held instruction; lw: MW_RD=RD, MW_ALUout=dmem_rdata; sw: MW_RD=0, MW_ALUout=dmem_addr.
REQ-022 Each cycle stall=1 SHALL present a bubble: MW_RD=0, MW_ALUout=0, branch_taken=0.
REQ-023 dmem_ack while in IDLE SHALL be ignored.
REQ-024 DX_lwFlag and DX_swFlag both high SHALL be treated as lw.
REQ-025 Zero-latency ack (ack in first MEM_WAIT cycle) SHALL give a 2-cycle lw/sw total.

Reset
REQ-026 rst low SHALL asynchronously force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, MW_RD=0, MW_ALUout=0, MW_compareFlag=0, branch_taken=0, branch_target=0.
REQ-027 Reset during MEM_WAIT SHALL abandon the access; a late dmem_ack after reset release SHALL be ignored.

Structure
REQ-028 ALUctr codes (ADD/SUB/CMP) and compareFlag codes (SLT/BEQ/J/BNE) SHALL live in a shared package also used by decode.
REQ-029 Combinational ALU/compare logic SHALL be one sub-module alu_unit; FSM and pipeline registers in execute_memory.

Verification
REQ-030 add A=5,B=7,RD=3 -> next cycle MW_RD=3, MW_ALUout=12, stall never high.
REQ-031 slt A=0xFFFFFFFF,B=1,RD=4 -> MW_ALUout=1; sub A=3,B=5 -> MW_ALUout=0xFFFFFFFE.
REQ-032 beq A=B=9, DX_PC=0x100, imm=0xFFFFFFFE -> branch_taken 1-cycle pulse, branch_target=0xFC; bne same operands -> no pulse.
REQ-033 lw A=0x40,B=8,RD=2, ack after 3 wait cycles, rdata=0xDEADBEEF -> dmem_addr=0x48, dmem_we=0, stall high 4 cycles, then MW_RD=2, MW_ALUout=0xDEADBEEF.
REQ-034 sw A=0x10,B=4,DX_immediate=0x55 -> dmem_we=1, addr=0x14, wdata=0x55; MW_RD=0 after ack.
REQ-035 rst low mid-MEM_WAIT, then ack after release -> dmem_req=0 immediately, state IDLE, no writeback.

Source files
------------

// File: rtl/execute_memory_pkg.sv
// execute_memory_pkg: opcode/branch-class codes shared by decode and execute.
package execute_memory_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_CMP = 3'd2
  } alu_ctr_e;
  typedef enum logic [2:0] {
    CMP_SLT = 3'd0,
    CMP_BEQ = 3'd1,
    CMP_J   = 3'd2,
    CMP_BNE = 3'd3
  } cmp_flag_e;
  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;
  function automatic logic is_branch(input logic [2:0] cf);
    return cf == CMP_BEQ || cf == CMP_J || cf == CMP_BNE;
  endfunction
endpackage

// File: rtl/execute_memory_alu.sv
// alu_unit: combinational ALU, signed compare and branch/jump target resolution.
module alu_unit
  import execute_memory_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [2:0]  alu_ctr_i,
  input  logic [2:0]  cmp_flag_i,
  output logic [31:0] result_o,
  output logic [31:0] target_o,
  output logic        branch_o,
  output logic        taken_o
);
  logic slt;
  always_comb begin
    slt      = $signed(a_i) < $signed(b_i);
    branch_o = is_branch(cmp_flag_i);
    taken_o  = (cmp_flag_i == CMP_J) ||
               (cmp_flag_i == CMP_BEQ && a_i == b_i) ||
               (cmp_flag_i == CMP_BNE && a_i != b_i);
    target_o = cmp_flag_i == CMP_J ? {pc_i[31:28], b_i[25:0], 2'b00}
                                   : pc_i + 32'd4 + (imm_i << 2);
    result_o = alu_ctr_i == ALU_ADD ? a_i + b_i :
               alu_ctr_i == ALU_SUB ? a_i - b_i :
               (alu_ctr_i == ALU_CMP && cmp_flag_i == CMP_SLT) ? {31'b0, slt} : 32'b0;
  end
endmodule

// File: rtl/execute_memory.sv
// execute_memory: execute stage with a blocking data-memory handshake and MW pipeline registers.
module execute_memory
  import execute_memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] DX_PC,
  input  logic [31:0] DX_immediate,
  input  logic [4:0]  RD,
  input  logic [2:0]  ALUctr,
  input  logic [2:0]  DX_compareFlag,
  input  logic        DX_lwFlag,
  input  logic        DX_swFlag,
  output logic [4:0]  MW_RD,
  output logic [31:0] MW_ALUout,
  output logic [2:0]  MW_compareFlag,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);
  state_e      state_q, state_d;
  logic [31:0] alu_result, alu_target;
  logic        alu_branch, alu_taken;
  logic        mem_op, take_alu, take_mem;
  logic [31:0] addr_q, wdata_q, mw_alu_q, mw_alu_d, tgt_q, tgt_d;
  logic        we_q, lw_q, bt_q, bt_d;
  logic [4:0]  rd_q, mw_rd_q, mw_rd_d;
  logic [2:0]  cf_q, mw_cf_q, mw_cf_d;
  assign mem_op = DX_lwFlag | DX_swFlag;
  alu_unit u_alu (
    .a_i       (A),
    .b_i       (B),
    .pc_i      (DX_PC),
    .imm_i     (DX_immediate),
    .alu_ctr_i (ALUctr),
    .cmp_flag_i(DX_compareFlag),
    .result_o  (alu_result),
    .target_o  (alu_target),
    .branch_o  (alu_branch),
    .taken_o   (alu_taken)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (mem_op ? MEM_WAIT : IDLE)
                              : (dmem_ack ? IDLE : MEM_WAIT);
  end
  // Everything not consumed this cycle (stalled or waiting) writes back a bubble.
  always_comb begin
    take_alu = state_q == IDLE && !mem_op;
    take_mem = state_q == MEM_WAIT && dmem_ack;
    stall    = (state_q == IDLE && mem_op) || (state_q == MEM_WAIT && !dmem_ack);
    dmem_req = state_q == MEM_WAIT;
    mw_rd_d  = take_alu ? (alu_branch ? 5'd0 : RD) :
               take_mem ? (lw_q ? rd_q : 5'd0) : 5'd0;
    mw_alu_d = take_alu ? (alu_branch ? {31'b0, alu_taken} : alu_result) :
               take_mem ? (lw_q ? dmem_rdata : addr_q) : 32'd0;
    mw_cf_d  = take_alu ? DX_compareFlag : take_mem ? cf_q : 3'd0;
    bt_d     = take_alu && alu_branch && alu_taken;
    tgt_d    = bt_d ? alu_target : tgt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      lw_q     <= 1'b0;
      rd_q     <= '0;
      cf_q     <= '0;
      mw_rd_q  <= '0;
      mw_alu_q <= '0;
      mw_cf_q  <= '0;
      bt_q     <= 1'b0;
      tgt_q    <= '0;
    end else begin
      if (state_q == IDLE && mem_op) begin
        addr_q  <= A + B;
        wdata_q <= DX_immediate;
        we_q    <= DX_swFlag && !DX_lwFlag;
        lw_q    <= DX_lwFlag;
        rd_q    <= RD;
        cf_q    <= DX_compareFlag;
      end
      mw_rd_q  <= mw_rd_d;
      mw_alu_q <= mw_alu_d;
      mw_cf_q  <= mw_cf_d;
      bt_q     <= bt_d;
      tgt_q    <= tgt_d;
    end
  end
  assign MW_RD          = mw_rd_q;
  assign MW_ALUout      = mw_alu_q;
  assign MW_compareFlag = mw_cf_q;
  assign branch_taken   = bt_q;
  assign branch_target  = tgt_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
endmodule

// File: tb/tb_execute_memory.sv
// tb_execute_memory: directed vectors checked against an instruction-level model every cycle.
module tb_execute_memory;
  logic        clk, rst;
  logic [31:0] A, B, DX_PC, DX_immediate, dmem_rdata;
  logic [4:0]  RD;
  logic [2:0]  ALUctr, DX_compareFlag;
  logic        DX_lwFlag, DX_swFlag, dmem_ack;
  logic [4:0]  MW_RD;
  logic [31:0] MW_ALUout, branch_target, dmem_addr, dmem_wdata;
  logic [2:0]  MW_compareFlag;
  logic        branch_taken, stall, dmem_req, dmem_we;
  int n_chk = 0, n_err = 0;

  execute_memory dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .DX_PC(DX_PC), .DX_immediate(DX_immediate),
    .RD(RD), .ALUctr(ALUctr), .DX_compareFlag(DX_compareFlag),
    .DX_lwFlag(DX_lwFlag), .DX_swFlag(DX_swFlag),
    .MW_RD(MW_RD), .MW_ALUout(MW_ALUout), .MW_compareFlag(MW_compareFlag),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: a memory op occupies one issue cycle plus the wait for ack.
  logic        m_wait, m_we, h_lw, e_bt;
  logic [31:0] m_addr, m_wdata, e_alu, e_tgt;
  logic [4:0]  h_rd, e_rd;
  logic [2:0]  h_cf, e_cf;
  always @(posedge clk or negedge rst) begin
    logic br, tk;
    if (!rst) begin
      m_wait = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      e_rd = 0; e_alu = 0; e_cf = 0; e_bt = 0; e_tgt = 0;
    end else if (!m_wait && (DX_lwFlag || DX_swFlag)) begin
      m_addr = A + B; m_wdata = DX_immediate; m_we = !DX_lwFlag;
      h_lw = DX_lwFlag; h_rd = RD; h_cf = DX_compareFlag; m_wait = 1;
      e_rd = 0; e_alu = 0; e_cf = 0; e_bt = 0;
    end else if (m_wait) begin
      e_bt = 0;
      if (dmem_ack) begin
        e_rd = h_lw ? h_rd : 5'd0;
        e_alu = h_lw ? dmem_rdata : m_addr;
        e_cf = h_cf; m_wait = 0;
      end else begin
        e_rd = 0; e_alu = 0; e_cf = 0;
      end
    end else begin
      br = DX_compareFlag inside {3'd1, 3'd2, 3'd3};
      tk = DX_compareFlag == 2 || (DX_compareFlag == 1 && A == B) || (DX_compareFlag == 3 && A != B);
      e_bt = br && tk;
      if (e_bt) e_tgt = DX_compareFlag == 2 ? {DX_PC[31:28], B[25:0], 2'b00} : DX_PC + 4 + DX_immediate * 4;
      e_rd = br ? 5'd0 : RD;
      e_cf = DX_compareFlag;
      if (br) e_alu = {31'b0, tk};
      else case (ALUctr)
        3'd0: e_alu = A + B;
        3'd1: e_alu = A - B;
        3'd2: e_alu = (DX_compareFlag == 0 && $signed(A) < $signed(B)) ? 32'd1 : 32'd0;
        default: e_alu = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("mw_rd", {27'b0, MW_RD}, {27'b0, e_rd});
    chk("mw_alu", MW_ALUout, e_alu);
    chk("mw_cf", {29'b0, MW_compareFlag}, {29'b0, e_cf});
    chk("br_taken", {31'b0, branch_taken}, {31'b0, e_bt});
    chk("br_target", branch_target, e_tgt);
    chk("dmem_req", {31'b0, dmem_req}, {31'b0, m_wait});
    chk("dmem_addr", dmem_addr, m_addr);
    chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_we});
    chk("dmem_wdata", dmem_wdata, m_wdata);
    chk("stall", {31'b0, stall},
        {31'b0, (!m_wait && (DX_lwFlag || DX_swFlag)) || (m_wait && !dmem_ack)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [2:0] ctr, input logic [2:0] cf, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [4:0] rd, input logic lw, input logic sw);
    ALUctr = ctr; DX_compareFlag = cf; A = a; B = b; DX_PC = pc;
    DX_immediate = imm; RD = rd; DX_lwFlag = lw; DX_swFlag = sw;
  endtask

  initial begin
    int cnt;
    rst = 0; dmem_ack = 0; dmem_rdata = 0;
    set(7, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_mw_rd", {27'b0, MW_RD}, 0);
    chk("rst_mw_alu", MW_ALUout, 0);
    chk("rst_target", branch_target, 0);
    chk("rst_req", {31'b0, dmem_req}, 0);
    rst = 1;
    set(0, 0, 5, 7, 0, 0, 3, 0, 0); step();
    chk("add_rd", {27'b0, MW_RD}, 3);
    chk("add_out", MW_ALUout, 12);
    set(2, 0, 32'hFFFF_FFFF, 1, 0, 0, 4, 0, 0); step();
    chk("slt_out", MW_ALUout, 1);
    set(1, 0, 3, 5, 0, 0, 5, 0, 0); step();
    chk("sub_out", MW_ALUout, 32'hFFFF_FFFE);
    set(2, 1, 9, 9, 32'h100, 32'hFFFF_FFFE, 6, 0, 0); step();
    chk("beq_taken", {31'b0, branch_taken}, 1);
    chk("beq_target", branch_target, 32'hFC);
    chk("beq_rd", {27'b0, MW_RD}, 0);
    set(2, 3, 9, 9, 32'h100, 32'hFFFF_FFFE, 6, 0, 0); step();
    chk("bne_taken", {31'b0, branch_taken}, 0);
    chk("bne_target_held", branch_target, 32'hFC);
    set(2, 2, 0, 32'h123, 32'h3000_0010, 0, 0, 0, 0); step();
    chk("j_target", branch_target, 32'h3000_048C);
    set(7, 0, 1, 1, 0, 0, 0, 0, 0); step();
    chk("pulse_end", {31'b0, branch_taken}, 0);
    set(0, 0, 32'h40, 8, 0, 0, 2, 1, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (stall) cnt++;
      step();
      if (k == 0) begin
        chk("lw_addr", dmem_addr, 32'h48);
        chk("lw_we", {31'b0, dmem_we}, 0);
      end
    end
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lw_stall_drop", {31'b0, stall}, 0);
    step();
    dmem_ack = 0; set(7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lw_stall_cycles", cnt, 4);
    chk("lw_rd", {27'b0, MW_RD}, 2);
    chk("lw_data", MW_ALUout, 32'hDEAD_BEEF);
    set(0, 0, 32'h10, 4, 0, 32'h55, 8, 0, 1); step();
    chk("sw_we", {31'b0, dmem_we}, 1);
    chk("sw_addr", dmem_addr, 32'h14);
    chk("sw_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1; step();
    dmem_ack = 0; set(7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sw_rd", {27'b0, MW_RD}, 0);
    chk("sw_out", MW_ALUout, 32'h14);
    set(0, 0, 1, 2, 0, 32'h99, 7, 1, 1); step();
    chk("both_we", {31'b0, dmem_we}, 0);
    dmem_ack = 1; dmem_rdata = 32'hA5; step();
    dmem_ack = 0; set(7, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("both_rd", {27'b0, MW_RD}, 7);
    chk("both_data", MW_ALUout, 32'hA5);
    set(0, 0, 2, 3, 0, 0, 1, 0, 0); dmem_ack = 1; step();
    dmem_ack = 0;
    chk("idle_ack_out", MW_ALUout, 5);
    chk("idle_ack_req", {31'b0, dmem_req}, 0);
    set(5, 0, 9, 9, 0, 0, 9, 0, 0); step();
    chk("op5_out", MW_ALUout, 0);
    chk("op5_rd", {27'b0, MW_RD}, 9);
    set(0, 0, 32'h20, 0, 0, 0, 3, 1, 0); step(); step();
    chk("mid_req", {31'b0, dmem_req}, 1);
    #1 rst = 0;
    #1 chk("async_req", {31'b0, dmem_req}, 0);
    set(7, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1; dmem_ack = 1; dmem_rdata = 32'h77;
    step();
    dmem_ack = 0;
    chk("late_ack_rd", {27'b0, MW_RD}, 0);
    chk("late_ack_out", MW_ALUout, 0);
    chk("late_ack_req", {31'b0, dmem_req}, 0);
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
